// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ack memory handshake,
// issues the instruction to the decoder and resolves the next PC on completion.
module fetch_stage #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [5:0]  op,
  output logic [31:0] pc,
  output logic [31:0] pcplus4,
  output logic        instr_valid,
  input  logic        instr_done,
  input  logic        branch,
  input  logic        branch_greater_equal,
  input  logic        jump,
  input  logic        zero,
  input  logic        ge,
  output logic [31:0] instret
);

  typedef enum logic {FETCH, ISSUE} state_t;

  state_t      state, state_nxt;
  logic        taken;
  logic [31:0] branch_off;
  logic [31:0] next_pc;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= FETCH;
      pc      <= PC_RESET;
      instr   <= '0;
      instret <= '0;
    end else begin
      state <= state_nxt;
      if (state == FETCH && imem_ack)
        instr <= imem_rdata;
      if (state == ISSUE && instr_done) begin
        pc      <= next_pc;
        instret <= instret + 32'd1;
      end
    end
  end

  // Handshake outputs are gated by reset so nothing is requested or issued while it is held.
  always_comb begin
    state_nxt   = state;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    case (state)
      FETCH: begin
        imem_req = reset;
        if (imem_ack) state_nxt = ISSUE;
      end
      ISSUE: begin
        instr_valid = reset;
        if (instr_done) state_nxt = FETCH;
      end
      default: state_nxt = FETCH;
    endcase
  end

  assign imem_addr = pc;
  assign op        = instr[31:26];
  assign pcplus4   = pc + 32'd4;

  // Only consumed on an instr_done edge in ISSUE, so X on the controls elsewhere is harmless.
  always_comb begin
    taken      = branch & (branch_greater_equal ? ge : zero);
    branch_off = {{14{instr[15]}}, instr[15:0], 2'b00};
    if (jump)
      next_pc = {pcplus4[31:28], instr[25:0], 2'b00};
    else if (taken)
      next_pc = pcplus4 + branch_off;
    else
      next_pc = pcplus4;
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: expected fetch addresses are queued when an
// instruction completes and checked when the next fetch request appears.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [5:0]  op;
  logic [31:0] pc;
  logic [31:0] pcplus4;
  logic        instr_valid;
  logic        instr_done;
  logic        branch, branch_greater_equal, jump, zero, ge;
  logic [31:0] instret;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_pc_q[$];
  logic [31:0] exp_instret;
  logic [31:0] cur_pc;

  fetch_stage #(.PC_RESET(32'h0000_0000)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .op(op), .pc(pc), .pcplus4(pcplus4), .instr_valid(instr_valid),
    .instr_done(instr_done), .branch(branch), .branch_greater_equal(branch_greater_equal),
    .jump(jump), .zero(zero), .ge(ge), .instret(instret)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for a fetch request, check its address against the scoreboard,
  // optionally withhold ack, then return the word and check the issued instruction.
  task automatic do_fetch(input logic [31:0] word, input int unsigned waits);
    int unsigned budget;
    budget = 0;
    while (imem_req !== 1'b1 && budget < 20) begin
      step();
      budget++;
    end
    chk("fetch_req", {31'd0, imem_req}, 32'd1);
    if (exp_pc_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL scoreboard_empty: observed 0 entries expected 1");
      cur_pc = imem_addr;
    end else begin
      cur_pc = exp_pc_q.pop_front();
      chk("fetch_addr", imem_addr, cur_pc);
    end
    for (int unsigned i = 0; i < waits; i++) begin
      imem_ack = 1'b0;
      step();
      chk("wait_addr", imem_addr, cur_pc);
      chk("wait_valid", {31'd0, instr_valid}, 32'd0);
    end
    imem_ack   = 1'b1;
    imem_rdata = word;
    step();
    imem_ack   = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    #1;
    chk("issue_valid", {31'd0, instr_valid}, 32'd1);
    chk("issue_instr", instr, word);
    chk("issue_pc", pc, cur_pc);
    chk("issue_req", {31'd0, imem_req}, 32'd0);
  endtask

  task automatic do_done(input logic br, input logic bge, input logic j,
                         input logic z, input logic g, input logic [31:0] exp_next);
    branch = br; branch_greater_equal = bge; jump = j; zero = z; ge = g;
    instr_done = 1'b1;
    exp_pc_q.push_back(exp_next);
    exp_instret = exp_instret + 32'd1;
    step();
    instr_done = 1'b0;
    branch = 1'bx; branch_greater_equal = 1'bx; jump = 1'bx; zero = 1'bx; ge = 1'bx;
    #1;
    chk("instret", instret, exp_instret);
    chk("done_valid", {31'd0, instr_valid}, 32'd0);
  endtask

  initial begin
    reset = 1'b0; imem_ack = 1'b0; imem_rdata = '0; instr_done = 1'b0;
    branch = 1'b0; branch_greater_equal = 1'b0; jump = 1'b0; zero = 1'b0; ge = 1'b0;
    exp_instret = '0;
    cur_pc = '0;

    // 1: reset held three cycles with a stray ack that must be ignored
    for (int i = 0; i < 3; i++) begin
      imem_ack = (i == 1);
      step();
      chk("rst_req", {31'd0, imem_req}, 32'd0);
      chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    end
    imem_ack = 1'b0;
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_instret", instret, 32'h0);
    reset = 1'b1;
    #1;
    exp_pc_q.push_back(32'h0);
    do_fetch(32'h2008_0005, 0);
    chk("op_addi", {26'd0, op}, 32'h08);
    chk("pcplus4_0", pcplus4, 32'h4);

    // 2: sequential completion, then a fetch with three wait cycles
    do_done(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h4);
    chk("seq_pc", pc, 32'h4);
    do_fetch(32'h0000_0020, 3);
    do_done(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h8);

    // 3: BEQ backwards when zero, fall through when not
    do_fetch(32'h1000_FFFE, 1);
    do_done(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h4);
    do_fetch(32'h0000_0020, 0);
    do_done(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h8);
    do_fetch(32'h1000_FFFE, 0);
    do_done(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'hC);
    do_fetch(32'h0800_0008, 0);
    do_done(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h20);

    // 4: BGE uses ge and ignores zero
    do_fetch(32'h0400_0003, 0);
    do_done(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h30);
    do_fetch(32'h0800_0008, 2);
    do_done(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h20);
    do_fetch(32'h0400_0003, 0);
    do_done(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h24);

    // 5: climb into the 0x1xxx_xxxx region, then jump beats a taken branch
    do_fetch(32'h0BFF_FFFF, 0);
    do_done(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0FFF_FFFC);
    do_fetch(32'h0800_0010, 0);
    do_done(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h1000_0040);
    do_fetch(32'h0800_0010, 0);
    do_done(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h1000_0040);

    // 6a: stray instr_done while fetching is ignored
    instr_done = 1'b1;
    step();
    instr_done = 1'b0;
    chk("stray_instret", instret, exp_instret);
    chk("stray_req", {31'd0, imem_req}, 32'd1);
    chk("stray_addr", imem_addr, 32'h1000_0040);

    // 6b: reset in the middle of an unacked fetch
    reset = 1'b0;
    #1;
    chk("midrst_req_comb", {31'd0, imem_req}, 32'd0);
    step();
    chk("midrst_req", {31'd0, imem_req}, 32'd0);
    chk("midrst_pc", pc, 32'h0);
    chk("midrst_instret", instret, 32'h0);
    reset = 1'b1;
    exp_instret = '0;
    exp_pc_q.delete();
    exp_pc_q.push_back(32'h0);

    // 6c: branch backwards from 0 wraps to the top word, then pcplus4 wraps to 0
    do_fetch(32'h1000_FFFE, 0);
    do_done(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFC);
    do_fetch(32'h0000_0020, 0);
    chk("pcplus4_wrap", pcplus4, 32'h0);
    do_done(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    do_fetch(32'h2008_0005, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage directly upstream of the main decoder.
- Holds the PC and fetches instructions over a req/ack instruction-memory handshake.
- Presents the instruction and its opcode field to the decoder, then waits for the instruction to complete.
- On completion, computes the next PC from the decoder's branch, branch_greater_equal and jump controls plus the ALU flags.

Parameters:
PC_RESET, 32'h0000_0000, PC value loaded on reset; must be word-aligned.

Ports:
clk  in  1  clock; all state updates on rising edge.
reset  in  1  synchronous, active-low reset.
imem_req  out  1  fetch request; held high until acked.
imem_addr  out  32  fetch address; equals pc while imem_req=1.
imem_ack  in  1  memory has imem_rdata valid this cycle.
imem_rdata  in  32  fetched instruction word.
instr  out  32  registered instruction.
op  out  6  instr[31:26], driven to the decoder.
pc  out  32  address of instr.
pcplus4  out  32  pc+4 (mod 2^32).
instr_valid  out  1  instr/op/pc are valid for downstream.
instr_done  in  1  downstream completes the issued instruction this cycle; the control and flag inputs below are sampled here.
branch  in  1  decoder branch control.
branch_greater_equal  in  1  decoder bge control.
jump  in  1  decoder jump control.
zero  in  1  ALU result == 0.
ge  in  1  ALU signed srca >= srcb.
instret  out  32  count of completed instructions.

Behaviour:
- Reset (reset=0 at a rising edge), regardless of current state:
  - state<=FETCH, pc<=PC_RESET, instr<=0, instret<=0.
  - imem_req=0 and instr_valid=0 for as long as reset is held low.
  - Any outstanding fetch is abandoned.
- FSM states: FETCH, ISSUE.
  - FETCH: imem_req=1, imem_addr=pc, instr_valid=0.
    - On an edge with imem_ack=1: instr<=imem_rdata, go to ISSUE.
    - Otherwise stay in FETCH with the address held stable.
  - ISSUE: imem_req=0, instr_valid=1.
    - On an edge with instr_done=1: pc<=next_pc, instret<=instret+1, go to FETCH.
    - Otherwise hold instr/pc.
- imem_ack in the same cycle imem_req rises is legal (zero-wait memory). Minimum fetch time is 1 cycle; minimum issue-to-next-fetch time is 1 cycle.
- Ignored inputs:
  - imem_ack while not in FETCH, or while reset=0.
  - instr_done while not in ISSUE.
- Registered outputs: instr, pc, instret.
- Combinational outputs from state and registers: op, pcplus4, imem_req, instr_valid, imem_addr.
- next_pc, evaluated from inputs sampled on the instr_done edge:
  - taken = branch & (branch_greater_equal ? ge : zero).
  - If jump=1: {pcplus4[31:28], instr[25:0], 2'b00}. Jump has priority over branch.
  - Else if taken: pcplus4 + ({{14{instr[15]}}, instr[15:0], 2'b00}), 32-bit, mod 2^32.
  - Else: pcplus4.
- Arithmetic and range:
  - pc[1:0] is always 0.
  - pcplus4 at pc=32'hFFFF_FFFC is 32'h0000_0000.
  - Branch-target add wraps silently.
  - instret wraps from 32'hFFFF_FFFF to 0.
- X on branch, branch_greater_equal, jump, zero or ge is permitted outside instr_done cycles and must not corrupt state.

Test Plan:
1. Reset held 3 cycles, then released, memory acks in the same cycle with 32'h2008_0005:
   - imem_req=0 during reset.
   - Cycle after release: imem_req=1, imem_addr=0.
   - Next cycle: instr_valid=1, op=6'b001000, pc=0, pcplus4=4.
2. Sequential flow, instr_done with no branch/jump:
   - pc becomes 4, imem_req=1, instret=1.
   - Memory withholds ack 3 cycles: imem_addr stays 4 and instr_valid stays 0 throughout.
3. BEQ at pc=8, instr[15:0]=16'hFFFE:
   - zero=1 at done -> next pc=8+4-8=4.
   - Repeat with zero=0 -> next pc=12.
4. BGE at pc=0x20, imm=3, branch=1, branch_greater_equal=1:
   - ge=1, zero=0 -> next pc=0x30.
   - ge=0, zero=1 -> next pc=0x24 (zero must be ignored).
5. J at pc=0x1000_0040, instr[25:0]=26'h10, jump=1 and branch=1 simultaneously -> next pc=0x1000_0040; jump wins.
6. Boundary cases:
   - Reset asserted mid-FETCH (ack never given) -> pc=PC_RESET, imem_req drops.
   - Stray instr_done during FETCH -> ignored, instret unchanged.
   - pc=0xFFFF_FFFC with sequential done -> pc=0.
